// File: rtl/alu_op_dispatcher.sv
// Issue stage in front of a 4-bit combinational ALU: buffers requests, issues one op at a time,
// screens illegal selects and divide/modulo-by-zero, and returns results over valid/ready.
module alu_op_dispatcher #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  OP_MAX     = 8'h19,
  parameter int          CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic [7:0]       in_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [7:0]       alu_sel,
  input  logic [3:0]       alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_result,
  output logic [7:0]       out_op,
  output logic             out_err,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t state, state_next;

  logic [15:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             fifo_empty, fifo_full;
  logic             push, pop, capture, retire;

  logic [3:0] head_a, head_b;
  logic [7:0] head_op;
  logic       head_err;
  logic [7:0] cur_op;
  logic       cur_err;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;

  assign head_a   = mem[rd_ptr][15:12];
  assign head_b   = mem[rd_ptr][11:8];
  assign head_op  = mem[rd_ptr][7:0];
  // Screening is decided at issue time so the ALU is steered onto AND for bad ops.
  assign head_err = (head_op > OP_MAX) ||
                    (((head_op == 8'h01) || (head_op == 8'h04)) && (head_b == 4'd0));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_a, in_b, in_op};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    capture    = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        capture    = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          retire = 1'b1;
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = EXEC;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      cur_op     <= '0;
      cur_err    <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_op     <= '0;
      out_err    <= 1'b0;
      op_count   <= '0;
      err_count  <= '0;
    end else begin
      if (pop) begin
        alu_a   <= head_a;
        alu_b   <= head_b;
        alu_sel <= head_err ? 8'h10 : head_op;
        cur_op  <= head_op;
        cur_err <= head_err;
      end
      if (capture) begin
        out_result <= cur_err ? 4'd0 : alu_result;
        out_err    <= cur_err;
        out_op     <= cur_op;
        out_valid  <= 1'b1;
      end
      if (retire) begin
        out_valid <= 1'b0;
        if (op_count != '1) op_count <= op_count + 1'b1;
        if (out_err && (err_count != '1)) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Directed bench for alu_op_dispatcher with a small behavioural ALU on the alu_* side;
// a second instance with a 2-bit counter width exercises counter saturation.
module tb_alu_op_dispatcher;

  logic       clk;
  logic       rst;
  logic       in_valid, in_ready, out_ready, out_valid, out_err;
  logic [3:0] in_a, in_b, alu_a, alu_b, alu_result, out_result;
  logic [7:0] in_op, alu_sel, out_op;
  logic [7:0] op_count, err_count;

  logic       s_in_valid, s_in_ready, s_out_ready, s_out_valid, s_out_err;
  logic [3:0] s_in_a, s_in_b, s_alu_a, s_alu_b, s_alu_result, s_out_result;
  logic [7:0] s_in_op, s_alu_sel, s_out_op;
  logic [1:0] s_op_count, s_err_count;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [3:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [7:0] s);
    case (s)
      8'h01:   return (b != 0) ? a / b : 4'd0;
      8'h02:   return a + b;
      8'h03:   return a - b;
      8'h04:   return (b != 0) ? a % b : 4'd0;
      8'h10:   return a & b;
      8'h11:   return a | b;
      8'h19:   return a ^ b;
      default: return a;
    endcase
  endfunction

  assign alu_result   = alu_model(alu_a, alu_b, alu_sel);
  assign s_alu_result = alu_model(s_alu_a, s_alu_b, s_alu_sel);

  alu_op_dispatcher dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_op(out_op), .out_err(out_err), .op_count(op_count), .err_count(err_count)
  );

  alu_op_dispatcher #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a), .in_b(s_in_b), .in_op(s_in_op),
    .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_sel(s_alu_sel), .alu_result(s_alu_result),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_result(s_out_result),
    .out_op(s_out_op), .out_err(s_out_err), .op_count(s_op_count), .err_count(s_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 0; in_a = 0; in_b = 0; in_op = 0; out_ready = 0;
    s_in_valid = 0; s_in_a = 0; s_in_b = 0; s_in_op = 0; s_out_ready = 0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // One-cycle push; caller guarantees in_ready is high.
  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [7:0] op);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (alu_sel !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_alu_sel: got %h want 00", alu_sel); end
    n_cmp++; if (out_result !== 4'h0 || out_err !== 1'b0 || out_op !== 8'h00) begin
      n_bad++; $display("[TB] FAIL reset_out_fields: got res=%h err=%b op=%h want 0/0/00", out_result, out_err, out_op);
    end
    n_cmp++; if (op_count !== 8'd0 || err_count !== 8'd0) begin
      n_bad++; $display("[TB] FAIL reset_counters: got %0d/%0d want 0/0", op_count, err_count);
    end
  endtask

  task automatic test_basic_add();
    do_reset();
    out_ready = 1'b1;
    push(4'd3, 4'd5, 8'h02);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL add_valid_n: got %b want 0", out_valid); end
    step();
    n_cmp++; if (alu_a !== 4'd3 || alu_b !== 4'd5 || alu_sel !== 8'h02) begin
      n_bad++; $display("[TB] FAIL add_issue: got a=%h b=%h sel=%h want 3/5/02", alu_a, alu_b, alu_sel);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL add_valid_n1: got %b want 0", out_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL add_valid_n2: got %b want 1", out_valid); end
    n_cmp++; if (out_result !== 4'd8 || out_err !== 1'b0 || out_op !== 8'h02) begin
      n_bad++; $display("[TB] FAIL add_result: got res=%h err=%b op=%h want 8/0/02", out_result, out_err, out_op);
    end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL add_valid_drop: got %b want 0", out_valid); end
    n_cmp++; if (op_count !== 8'd1 || err_count !== 8'd0) begin
      n_bad++; $display("[TB] FAIL add_counters: got %0d/%0d want 1/0", op_count, err_count);
    end
  endtask

  task automatic test_div_zero();
    do_reset();
    out_ready = 1'b1;
    push(4'd9, 4'd0, 8'h01);
    step();
    n_cmp++; if (alu_sel !== 8'h10) begin n_bad++; $display("[TB] FAIL div0_alu_sel: got %h want 10", alu_sel); end
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 4'd0 || out_err !== 1'b1 || out_op !== 8'h01) begin
      n_bad++; $display("[TB] FAIL div0_result: got v=%b res=%h err=%b op=%h want 1/0/1/01", out_valid, out_result, out_err, out_op);
    end
    step();
    n_cmp++; if (op_count !== 8'd1 || err_count !== 8'd1) begin
      n_bad++; $display("[TB] FAIL div0_counters: got %0d/%0d want 1/1", op_count, err_count);
    end
  endtask

  task automatic test_op_range();
    do_reset();
    out_ready = 1'b1;
    push(4'd1, 4'd1, 8'h20);
    step();
    n_cmp++; if (alu_sel !== 8'h10) begin n_bad++; $display("[TB] FAIL illegal_alu_sel: got %h want 10", alu_sel); end
    step();
    n_cmp++; if (out_result !== 4'd0 || out_err !== 1'b1 || out_op !== 8'h20) begin
      n_bad++; $display("[TB] FAIL illegal_result: got res=%h err=%b op=%h want 0/1/20", out_result, out_err, out_op);
    end
    step();
    push(4'd6, 4'd3, 8'h19);
    step();
    n_cmp++; if (alu_sel !== 8'h19) begin n_bad++; $display("[TB] FAIL maxop_alu_sel: got %h want 19", alu_sel); end
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 4'd5 || out_err !== 1'b0 || out_op !== 8'h19) begin
      n_bad++; $display("[TB] FAIL maxop_result: got v=%b res=%h err=%b op=%h want 1/5/0/19", out_valid, out_result, out_err, out_op);
    end
    step();
    n_cmp++; if (op_count !== 8'd2 || err_count !== 8'd1) begin
      n_bad++; $display("[TB] FAIL range_counters: got %0d/%0d want 2/1", op_count, err_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] va [6] = '{4'd1, 4'd7, 4'd12, 4'd5, 4'd4, 4'd15};
    logic [3:0] vb [6] = '{4'd2, 4'd3, 4'd10, 4'd0, 4'd2, 4'd15};
    logic [7:0] vo [6] = '{8'h02, 8'h03, 8'h10, 8'h04, 8'h11, 8'h02};
    logic [3:0] er [5] = '{4'd3, 4'd4, 4'd8, 4'd0, 4'd6};
    logic       ee [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       seen;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_a = va[i]; in_b = vb[i]; in_op = vo[i];
      n_cmp++; if (in_ready !== (i < 5)) begin
        n_bad++; $display("[TB] FAIL fill_in_ready[%0d]: got %b want %b", i, in_ready, (i < 5));
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_result !== er[k] || out_err !== ee[k] || out_op !== vo[k]) begin
        n_bad++; $display("[TB] FAIL drain[%0d]: got v=%b res=%h err=%b op=%h want 1/%h/%b/%h",
                          k, out_valid, out_result, out_err, out_op, er[k], ee[k], vo[k]);
      end
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL drain_gap[%0d]: got %b want 0", k, out_valid); end
      step();
    end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("[TB] FAIL rejected_op_issued: got %b want 0", seen); end
    n_cmp++; if (op_count !== 8'd5 || err_count !== 8'd1) begin
      n_bad++; $display("[TB] FAIL drain_counters: got %0d/%0d want 5/1", op_count, err_count);
    end
  endtask

  task automatic test_reset_in_done();
    logic seen;
    do_reset();
    out_ready = 1'b1;
    push(4'd2, 4'd2, 8'h02);
    step(); step(); step();
    n_cmp++; if (op_count !== 8'd1) begin n_bad++; $display("[TB] FAIL pre_reset_count: got %0d want 1", op_count); end
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(4'(i + 1), 4'd1, 8'h02);
    step(); step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL pre_reset_valid: got %b want 1", out_valid); end
    rst = 1'b1;
    #2;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("[TB] FAIL async_reset: got v=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    n_cmp++; if (op_count !== 8'd0 || err_count !== 8'd0) begin
      n_bad++; $display("[TB] FAIL async_reset_counters: got %0d/%0d want 0/0", op_count, err_count);
    end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("[TB] FAIL stale_result: got %b want 0", seen); end
  endtask

  task automatic test_saturation();
    int cyc;
    do_reset();
    s_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc = 0;
      while (!s_in_ready && cyc < 20) begin step(); cyc++; end
      s_in_valid = 1'b1; s_in_a = 4'd1; s_in_b = 4'd1; s_in_op = 8'h20;
      step();
    end
    s_in_valid = 1'b0;
    for (int c = 0; c < 16; c++) step();
    n_cmp++; if (s_op_count !== 2'd3) begin n_bad++; $display("[TB] FAIL sat_op_count: got %0d want 3", s_op_count); end
    n_cmp++; if (s_err_count !== 2'd3) begin n_bad++; $display("[TB] FAIL sat_err_count: got %0d want 3", s_err_count); end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_div_zero();
    test_op_range();
    test_back_to_back();
    test_reset_in_done();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
